fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin arbiter that shares the nibble-packing FIFO's single 4-bit write port between two nibble producers. Grants are byte-atomic: once a requester wins, it keeps the port until it has written BURST complete bytes (low nibble, then high nibble each). The block sits directly in front of the FIFO input and drives its input_enable from the granted requester. It also honours the FIFO's input_valid (space available) back-pressure.

## Interface
- BURST, 1: bytes (nibble pairs) written per grant; legal 1..16
- CNT_W, 8: width of per-requester byte counters

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req0  in  1  requester 0 has a nibble on data0
- data0  in  4  requester 0 nibble
- ack0  out  1  requester 0 nibble accepted this cycle
- req1  in  1  requester 1 has a nibble on data1
- data1  in  4  requester 1 nibble
- ack1  out  1  requester 1 nibble accepted this cycle
- fifo_data  out  4  nibble to FIFO Data_In
- fifo_input_enable  out  1  to FIFO input_enable
- fifo_input_valid  in  1  from FIFO input_valid (FIFO can accept a nibble)
- grant  out  2  one-hot current owner, 2'b00 when idle
- busy  out  1  grant != 0
- bytes0  out  CNT_W  completed bytes from requester 0, wraps
- bytes1  out  CNT_W  completed bytes from requester 1, wraps

## Operation
- States: IDLE, LOW (expect low nibble), HIGH (expect high nibble). Registered owner g, round-robin pointer ptr (1 bit), burst counter bcnt (0..BURST-1).
- Transfer condition: state in {LOW, HIGH} and req[g] and fifo_input_valid. In that cycle, ack[g]=1. ack of the non-owner is always 0.
- fifo_input_enable = (state != IDLE) and req[g], combinational. fifo_data = data[g] when state != IDLE, else 4'h0.
- IDLE: both req low -> stay. Only one req high -> g = that requester. Both high -> g = ptr. Go to LOW, bcnt = 0.
- LOW: transfer -> HIGH. Otherwise hold.
- HIGH: transfer -> bytes[g] += 1 (mod 2^CNT_W).
  - If bcnt == BURST-1: ptr = ~g and go to IDLE.
  - Otherwise: bcnt += 1 and go to LOW.
  - No transfer -> hold.
- Owner dropping req mid-byte or mid-burst: the grant is NOT released; the arbiter waits indefinitely so FIFO nibble phase never desynchronises.
- FIFO full (fifo_input_valid=0): no transfer, no ack, state/counters frozen; fifo_input_enable may stay high (FIFO ignores it).
- Requesters must hold data stable while req is high until ack.

## Timing
- Reset values: state IDLE, grant 00, busy 0, ptr 0 (requester 0 first on a tie), bcnt 0, bytes0/bytes1 0, ack0/ack1 0, fifo_input_enable 0, fifo_data 0.
- Arbitration latency: req rising in IDLE at cycle N -> grant visible at N+1. The first ack is possible at N+1.
- Nibble throughput while owned and not stalled: 1 per cycle. A BURST-byte grant takes 2*BURST transfer cycles.
- After the final high nibble, there is one mandatory IDLE cycle before the next grant. Back-to-back contention therefore gives 2*BURST+1 cycles per grant.
- bytes[g] and ptr update on the edge ending the final high-nibble transfer cycle.
- rst asserted mid-byte or mid-burst: the next edge forces the reset state. Any partial byte is discarded. The FIFO shares the same rst, so write phase realigns.
- Simultaneous req0/req1 rising in IDLE: ptr decides. The loser keeps req high and is granted after the winner's burst.

## Test plan
- Reset then idle: rst 2 cycles, no req -> grant=00, fifo_input_enable=0, fifo_data=0, bytes0=bytes1=0.
- Single requester, BURST=1: req0 with nibbles 4'h5 then 4'hA -> grant=01 one cycle after req, ack0 on 2 consecutive cycles, FIFO receives 5 then A, bytes0=1, IDLE one cycle.
- Contention, BURST=2: req0 and req1 both high from reset -> grant sequence 01 (4 acks), idle, 10 (4 acks), idle, 01. bytes0/bytes1 alternate increments of 2.
- Back-pressure: drop fifo_input_valid for 3 cycles while in HIGH -> no acks, state held, resumes with the high nibble when valid returns.
- Owner stalls: req1 owner deasserts after the low nibble with req0 pending -> grant stays 10, no ack0, until req1 supplies the high nibble.
- Reset mid-byte and counter wrap: assert rst in HIGH -> IDLE/grant 00 next cycle. Then 256 bytes from req0 with CNT_W=8 -> bytes0 wraps to 0.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - byte-atomic round-robin arbiter for the nibble FIFO write port

module fifo_write_arbiter #(
  parameter int BURST = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [3:0]       data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [3:0]       data1,
  output logic             ack1,
  output logic [3:0]       fifo_data,
  output logic             fifo_input_enable,
  input  logic             fifo_input_valid,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [CNT_W-1:0] bytes0,
  output logic [CNT_W-1:0] bytes1
);

  localparam int BC_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BURST - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t           state, state_nxt;
  logic             g, g_nxt;
  logic             ptr, ptr_nxt;
  logic [BC_W-1:0]  bcnt, bcnt_nxt;
  logic [CNT_W-1:0] bytes0_nxt, bytes1_nxt;

  logic             owned;
  logic             req_g;
  logic [3:0]       data_g;
  logic             xfer;

  // State, owner, pointer and counters; everything freezes unless the FSM moves it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      g      <= 1'b0;
      ptr    <= 1'b0;
      bcnt   <= '0;
      bytes0 <= '0;
      bytes1 <= '0;
    end else begin
      state  <= state_nxt;
      g      <= g_nxt;
      ptr    <= ptr_nxt;
      bcnt   <= bcnt_nxt;
      bytes0 <= bytes0_nxt;
      bytes1 <= bytes1_nxt;
    end
  end

  // Next-state logic and the owner-steered FIFO port; grant is held until the burst completes.
  always_comb begin
    state_nxt  = state;
    g_nxt      = g;
    ptr_nxt    = ptr;
    bcnt_nxt   = bcnt;
    bytes0_nxt = bytes0;
    bytes1_nxt = bytes1;

    owned  = (state != IDLE);
    req_g  = g ? req1 : req0;
    data_g = g ? data1 : data0;
    xfer   = owned && req_g && fifo_input_valid;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          g_nxt     = (req0 && req1) ? ptr : req1;
          bcnt_nxt  = '0;
          state_nxt = LOW;
        end
      end
      LOW: begin
        if (xfer) state_nxt = HIGH;
      end
      HIGH: begin
        if (xfer) begin
          if (g) bytes1_nxt = bytes1 + CNT_W'(1);
          else   bytes0_nxt = bytes0 + CNT_W'(1);
          if (bcnt == BC_LAST) begin
            ptr_nxt   = ~g;
            state_nxt = IDLE;
          end else begin
            bcnt_nxt  = bcnt + BC_W'(1);
            state_nxt = LOW;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    ack0              = xfer && !g;
    ack1              = xfer && g;
    fifo_input_enable = owned && req_g;
    fifo_data         = owned ? data_g : 4'h0;
    grant             = owned ? (g ? 2'b10 : 2'b01) : 2'b00;
    busy              = owned;
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench for fifo_write_arbiter

module tb_fifo_write_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] data0, data1;
  logic       ack0, ack1;
  logic [3:0] fifo_data;
  logic       fifo_input_enable;
  logic       fifo_input_valid;
  logic [1:0] grant;
  logic       busy;
  logic [7:0] bytes0, bytes1;

  int errors = 0;
  int checks = 0;

  logic [3:0] q0[$];
  logic [3:0] q1[$];

  typedef struct {
    logic       r0, r1, v;
    logic [1:0] gnt;
    logic       a0, a1, en;
    logic [3:0] d;
    logic [7:0] b0, b1;
  } vec_t;

  vec_t tbl[$];

  fifo_write_arbiter #(.BURST(2), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .req0(req0),
    .data0(data0),
    .ack0(ack0),
    .req1(req1),
    .data1(data1),
    .ack1(ack1),
    .fifo_data(fifo_data),
    .fifo_input_enable(fifo_input_enable),
    .fifo_input_valid(fifo_input_valid),
    .grant(grant),
    .busy(busy),
    .bytes0(bytes0),
    .bytes1(bytes1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    fifo_input_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_en", fifo_input_enable, 1'b0);
    chk("rst_data", fifo_data, 4'h0);
    chk("rst_bytes0", bytes0, 8'd0);
    chk("rst_bytes1", bytes1, 8'd0);
    chk("rst_acks", {ack0, ack1}, 2'b00);
    rst = 1'b0;
  endtask

  // Called at a negedge; drives one nibble, waits for its ack, returns at the next negedge.
  task automatic put(input bit r, input logic [3:0] d, output int waited);
    logic       a, ao;
    logic [3:0] exp_d;
    waited = 0;
    if (r) begin req1 = 1'b1; data1 = d; q1.push_back(d); end
    else   begin req0 = 1'b1; data0 = d; q0.push_back(d); end
    forever begin
      #1;
      a  = r ? ack1 : ack0;
      ao = r ? ack0 : ack1;
      if (a) begin
        exp_d = r ? q1.pop_front() : q0.pop_front();
        chk("fifo_data", fifo_data, exp_d);
        chk("other_ack", ao, 1'b0);
        chk("fifo_en", fifo_input_enable, 1'b1);
        @(negedge clk);
        break;
      end
      @(negedge clk);
      waited++;
      if (waited > 50) begin
        errors++;
        checks++;
        $display("FAIL ack_timeout: requester %0d got no ack after %0d cycles", r, waited);
        if (r) void'(q1.pop_front()); else void'(q0.pop_front());
        break;
      end
    end
  endtask

  initial begin
    int w;
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    data0 = 4'h0;
    data1 = 4'h0;
    fifo_input_valid = 1'b1;

    // Contention with back-pressure, BURST=2, data0=3, data1=C
    //                  r0 r1 v   gnt  a0 a1 en  d     b0 b1
    tbl.push_back('{1, 1, 1, 2'b00, 0, 0, 0, 4'h0, 0, 0});
    tbl.push_back('{1, 1, 1, 2'b01, 1, 0, 1, 4'h3, 0, 0});
    tbl.push_back('{1, 1, 1, 2'b01, 1, 0, 1, 4'h3, 0, 0});
    tbl.push_back('{1, 1, 1, 2'b01, 1, 0, 1, 4'h3, 1, 0});
    tbl.push_back('{1, 1, 1, 2'b01, 1, 0, 1, 4'h3, 1, 0});
    tbl.push_back('{1, 1, 1, 2'b00, 0, 0, 0, 4'h0, 2, 0});
    tbl.push_back('{1, 1, 1, 2'b10, 0, 1, 1, 4'hC, 2, 0});
    tbl.push_back('{1, 1, 1, 2'b10, 0, 1, 1, 4'hC, 2, 0});
    tbl.push_back('{1, 1, 1, 2'b10, 0, 1, 1, 4'hC, 2, 1});
    tbl.push_back('{1, 1, 1, 2'b10, 0, 1, 1, 4'hC, 2, 1});
    tbl.push_back('{1, 1, 1, 2'b00, 0, 0, 0, 4'h0, 2, 2});
    tbl.push_back('{1, 1, 1, 2'b01, 1, 0, 1, 4'h3, 2, 2});
    tbl.push_back('{1, 1, 0, 2'b01, 0, 0, 1, 4'h3, 2, 2});
    tbl.push_back('{1, 1, 0, 2'b01, 0, 0, 1, 4'h3, 2, 2});
    tbl.push_back('{1, 1, 0, 2'b01, 0, 0, 1, 4'h3, 2, 2});
    tbl.push_back('{1, 1, 1, 2'b01, 1, 0, 1, 4'h3, 2, 2});
    tbl.push_back('{1, 1, 1, 2'b01, 1, 0, 1, 4'h3, 3, 2});
    tbl.push_back('{1, 1, 1, 2'b01, 1, 0, 1, 4'h3, 3, 2});
    tbl.push_back('{1, 1, 1, 2'b00, 0, 0, 0, 4'h0, 4, 2});
    tbl.push_back('{1, 1, 1, 2'b10, 0, 1, 1, 4'hC, 4, 2});

    do_reset();
    data0 = 4'h3;
    data1 = 4'hC;
    foreach (tbl[i]) begin
      @(negedge clk);
      req0 = tbl[i].r0;
      req1 = tbl[i].r1;
      fifo_input_valid = tbl[i].v;
      #1;
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].gnt);
      chk($sformatf("tbl%0d_busy", i), busy, |tbl[i].gnt);
      chk($sformatf("tbl%0d_acks", i), {ack0, ack1}, {tbl[i].a0, tbl[i].a1});
      chk($sformatf("tbl%0d_en", i), fifo_input_enable, tbl[i].en);
      chk($sformatf("tbl%0d_data", i), fifo_data, tbl[i].d);
      chk($sformatf("tbl%0d_bytes", i), {bytes0, bytes1}, {tbl[i].b0, tbl[i].b1});
    end

    // Single requester: grant one cycle after req, then one nibble per cycle
    do_reset();
    @(negedge clk);
    req0 = 1'b1;
    data0 = 4'h5;
    #1;
    chk("single_idle_grant", grant, 2'b00);
    chk("single_idle_ack", ack0, 1'b0);
    @(negedge clk);
    put(0, 4'h5, w); chk("single_lat0", w, 0);
    put(0, 4'hA, w); chk("single_lat1", w, 0);
    put(0, 4'h1, w); chk("single_lat2", w, 0);
    put(0, 4'h2, w); chk("single_lat3", w, 0);
    req0 = 1'b0;
    #1;
    chk("single_post_grant", grant, 2'b00);
    chk("single_bytes0", bytes0, 8'd2);

    // Owner stall: req1 holds the grant after its low nibble while req0 waits
    do_reset();
    @(negedge clk);
    put(1, 4'h7, w); chk("stall_first_wait", w, 1);
    req1 = 1'b0;
    req0 = 1'b1;
    data0 = 4'h9;
    repeat (3) begin
      #1;
      chk("stall_grant", grant, 2'b10);
      chk("stall_ack0", ack0, 1'b0);
      chk("stall_en", fifo_input_enable, 1'b0);
      @(negedge clk);
    end
    put(1, 4'h8, w); chk("stall_resume", w, 0);
    put(1, 4'h2, w);
    put(1, 4'h3, w);
    req1 = 1'b0;
    chk("stall_bytes1", bytes1, 8'd2);
    put(0, 4'h9, w); chk("stall_next_wait", w, 1);
    put(0, 4'h4, w);
    put(0, 4'h6, w);
    put(0, 4'h1, w);
    req0 = 1'b0;
    #1;
    chk("stall_bytes0", bytes0, 8'd2);

    // Reset mid-byte: partial byte discarded, state back to idle
    @(negedge clk);
    put(0, 4'hE, w);
    #1;
    chk("midrst_pre_grant", grant, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_en", fifo_input_enable, 1'b0);
    chk("midrst_bytes0", bytes0, 8'd0);
    rst = 1'b0;
    req0 = 1'b0;

    // Counter wrap: 256 bytes from requester 0
    @(negedge clk);
    for (int i = 0; i < 512; i++) begin
      if (i == 510) chk("wrap_bytes0_255", bytes0, 8'd255);
      put(0, i[3:0], w);
    end
    req0 = 1'b0;
    #1;
    chk("wrap_bytes0", bytes0, 8'd0);
    chk("wrap_bytes1", bytes1, 8'd0);
    chk("wrap_grant", grant, 2'b00);
    chk("sb_q0_empty", q0.size(), 0);
    chk("sb_q1_empty", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
